instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch-side initiator for the instruction memory (instru_file): drives its
//  word address A, captures read_data and hands instructions to decode on a
//  valid/ready interface, buffered in a FETCH_DEPTH-entry FIFO.
//  Supports branch/jump redirect with flush and out-of-range fetch faulting.
//  Sits between the PC/branch logic and the decode stage of the RV32 core.
// PARAMETERS
//  RESET_PC    32'h0  first fetch address after reset
//  MEM_DEPTH   256    instruction-memory words; legal byte addrs < MEM_DEPTH*4
//  FETCH_DEPTH 2      output FIFO entries (>=2)
//  NOP_INSTR   32'h00000013  instruction returned with a fault (addi x0,x0,0)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   asynchronous, active-low reset
//  fetch_en       in   1   1 = issue fetches; 0 = stop issuing, drain in-flight
//  A              out  32  address to instru_file (word aligned, A[1:0]=0)
//  read_data      in   32  instru_file data, valid 1 cycle after A is sampled
//  redirect_valid in   1   1-cycle pulse: restart fetch at redirect_pc
//  redirect_pc    in   32  new PC; bits [1:0] forced to 0
//  instr_valid    out  1   FIFO head valid
//  instr_ready    in   1   decode accepts head this cycle
//  instr          out  32  instruction at FIFO head
//  instr_pc       out  32  byte address of instr
//  instr_fault    out  1   head is a fault entry (instr = NOP_INSTR)
// BEHAVIOUR
//  Reset (reset=0, async): A=fetch_pc=RESET_PC, FIFO empty, instr_valid=0,
//   instr=0, instr_pc=0, instr_fault=0, no in-flight, state IDLE.
//  FSM: IDLE -fetch_en=1-> FETCH; FETCH -fetch_en=0-> IDLE;
//   FETCH -fault issued-> HALT; any state -redirect_valid-> FETCH if fetch_en
//   else IDLE. HALT issues nothing until redirect.
//  A = fetch_pc (registered). Issue at a rising edge when state=FETCH,
//   no redirect, and count + inflight - pop < FETCH_DEPTH. On issue:
//   inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps mod 2^32).
//  Edge after an issue: read_data pushed with inflight_pc, fault=0; unless
//   squashed by a redirect in between (data dropped, no push).
//  Fault: if fetch_pc >= MEM_DEPTH*4 when an issue would occur, push
//   {NOP_INSTR, fetch_pc, fault=1} directly (no memory access), fetch_pc held,
//   state->HALT. Only one fault entry is pushed.
//  Latency: issue edge t -> push at t+1 -> instr_valid high after t+1.
//   Redirect edge r -> first new instr_valid after r+2. Throughput 1/cycle
//   with instr_ready held high.
//  Output: instr_valid = FIFO non-empty; pop on instr_valid&&instr_ready;
//   instr/instr_pc/instr_fault stable while valid && !ready. Push and pop in
//   the same cycle allowed (count unchanged). No overflow by credit rule.
//  Redirect: FIFO flushed, in-flight squashed, fetch_pc<=redirect_pc&~3.
//   A handshake in the redirect cycle counts as completed; redirect has
//   priority over issue and push in that cycle.
//  fetch_en=0: no new issue; in-flight push and FIFO drain still occur.
//  Reset mid-operation: all state cleared at once; in-flight data discarded.
// TESTING
//  1 Mem[i]=32'h1000_0000+i, fetch_en=1, ready=1 -> instr_pc 0,4,8,.. with
//    instr 1000_0000,1000_0001,.. one per cycle after 2-cycle startup.
//  2 Stream, ready=0 for 5 cycles at pc 0x8 -> instr=1000_0002 held, FIFO
//    holds <=2, A stalls; ready=1 -> 0x8,0xC,0x10 with no loss/duplication.
//  3 Stream, redirect_pc=0x3FC -> in-flight dropped, next instr_pc=0x3FC
//    (1000_00FF), then pc 0x400 fault: instr=0x00000013, instr_fault=1,
//    no further valid until redirect_pc=0x0 restarts at Mem[0].
//  4 redirect_pc=0x13 -> next instr_pc=0x10, instr=1000_0004.
//  5 reset=0 mid-stream (between edges) -> instr_valid=0 and A=RESET_PC
//    immediately; after release fetch restarts at RESET_PC.
//  6 fetch_en=0 with one in-flight -> that word delivered, A holds, then
//    instr_valid=0; fetch_en=1 resumes at next sequential pc.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory port, control inputs and the decode handshake.
// The master modport is the fetch unit; the slave modport is its environment.
interface instr_fetch_unit_if;
    logic        fetch_en;
    logic [31:0] A;
    logic [31:0] read_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    modport master (
        input  fetch_en,
        output A,
        input  read_data,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output instr_fault
    );

    modport slave (
        output fetch_en,
        input  A,
        output read_data,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  instr_fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word addresses to instruction memory, buffers returned
// words in a small FIFO for decode, and handles redirects and out-of-range fetch faults.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned FETCH_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned PtrW     = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;
    localparam int unsigned CntW     = $clog2(FETCH_DEPTH + 1);
    localparam logic [32:0] MemBytes = 33'(MEM_DEPTH) * 33'd4;

    typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_nx;
    logic [CntW-1:0] count_q, count_d;
    entry_t          fifo_q [FETCH_DEPTH];

    logic       redirect, pop, credit_ok, pc_oob, issue_try, issue, fault, push_mem;
    logic [1:0] n_push;
    entry_t     mem_entry, fault_entry, head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == FETCH_DEPTH - 1) ? '0 : p + PtrW'(1);
    endfunction

    assign redirect  = bus.redirect_valid;
    assign pop       = (count_q != '0) && bus.instr_ready;
    // Credit counts the in-flight word so a returning read always has a free slot.
    assign credit_ok = (32'(count_q) + 32'(inflight_q) - 32'(pop)) < FETCH_DEPTH;
    assign pc_oob    = {1'b0, fetch_pc_q} >= MemBytes;
    assign issue_try = (state_q == StFetch) && bus.fetch_en && !redirect && credit_ok;
    assign issue     = issue_try && !pc_oob;
    assign fault     = issue_try && pc_oob;
    assign push_mem  = inflight_q && !redirect;
    assign n_push    = 2'(push_mem) + 2'(fault);
    assign wr_ptr_nx = ptr_inc(wr_ptr_q);

    assign mem_entry   = '{instr: bus.read_data, pc: inflight_pc_q, fault: 1'b0};
    assign fault_entry = '{instr: NOP_INSTR, pc: fetch_pc_q, fault: 1'b1};

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = bus.fetch_en ? StFetch : StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.fetch_en) state_d = StFetch;
                StFetch: begin
                    if (!bus.fetch_en) state_d = StIdle;
                    else if (fault)    state_d = StHalt;
                end
                StHalt:  state_d = StHalt;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q + CntW'(n_push) - CntW'(pop);
        if (n_push == 2'd1)      wr_ptr_d = wr_ptr_nx;
        else if (n_push == 2'd2) wr_ptr_d = ptr_inc(wr_ptr_nx);
        if (issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
        end
        if (redirect) begin
            fetch_pc_d = bus.redirect_pc & ~32'd3;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // A returning word and a fault can land on the same edge; the word goes first.
    always_ff @(posedge clk) begin
        if (push_mem) fifo_q[wr_ptr_q] <= mem_entry;
        if (fault)    fifo_q[push_mem ? wr_ptr_nx : wr_ptr_q] <= fault_entry;
    end

    assign head            = fifo_q[rd_ptr_q];
    assign bus.A           = fetch_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = bus.instr_valid ? head.instr : '0;
    assign bus.instr_pc    = bus.instr_valid ? head.pc    : '0;
    assign bus.instr_fault = bus.instr_valid ? head.fault : 1'b0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed latency/redirect/reset scenarios plus random traffic,
// all checked against an in-order stream model of the expected instruction sequence.
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] MEM_BYTES = 32'd1024;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC    (32'h0),
        .MEM_DEPTH   (256),
        .FETCH_DEPTH (2),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: Mem[i] = 0x1000_0000 + i, one-cycle read latency.
    always @(posedge clk) bus.read_data <= 32'h1000_0000 + {2'b00, bus.A[31:2]};

    int          tests = 0;
    int          fails = 0;
    int          deliveries = 0;
    logic [31:0] exp_pc = 32'h0;
    bit          halted = 1'b0;
    logic [31:0] rpc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with this cycle's inputs applied; checks the head against the
    // stream model, accounts for the upcoming edge, and returns at the next negedge.
    task automatic tick();
        logic        exp_fault;
        logic [31:0] exp_instr;
        exp_fault = (exp_pc >= MEM_BYTES);
        exp_instr = exp_fault ? NOP : 32'h1000_0000 + (exp_pc >> 2);
        check("A_align", 32'(bus.A[1:0]), 32'h0);
        if (halted) begin
            check("no_valid_after_fault", 32'(bus.instr_valid), 32'h0);
        end else if (bus.instr_valid) begin
            check("head_pc", bus.instr_pc, exp_pc);
            check("head_instr", bus.instr, exp_instr);
            check("head_fault", 32'(bus.instr_fault), 32'(exp_fault));
            if (bus.instr_ready) begin
                deliveries++;
                if (exp_fault) halted = 1'b1;
                else           exp_pc = exp_pc + 32'd4;
            end
        end
        if (bus.redirect_valid) begin
            exp_pc = bus.redirect_pc & ~32'd3;
            halted = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset between edges, checks the asynchronous effect, releases at the next negedge.
    task automatic apply_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_A", bus.A, 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_pc", bus.instr_pc, 32'h0);
        check("rst_fault", 32'(bus.instr_fault), 32'h0);
        exp_pc                 = 32'h0;
        halted                 = 1'b0;
        bus.fetch_en           = 1'b0;
        bus.redirect_valid     = 1'b0;
        bus.instr_ready        = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!bus.instr_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.instr_valid), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;
        @(negedge clk);
        apply_reset();

        // Startup latency and one-per-cycle streaming.
        bus.fetch_en    = 1'b1;
        bus.instr_ready = 1'b1;
        tick(); check("t1_lat_e1", 32'(bus.instr_valid), 32'h0);
        tick(); check("t1_lat_e2", 32'(bus.instr_valid), 32'h0);
        tick(); check("t1_first_valid", 32'(bus.instr_valid), 32'h1);
        for (int i = 0; i < 2; i++) begin
            check("t1_valid", 32'(bus.instr_valid), 32'h1);
            check("t1_pc", bus.instr_pc, 32'(i * 4));
            check("t1_instr", bus.instr, 32'h1000_0000 + 32'(i));
            tick();
        end

        // Back-pressure at pc 0x8 for five cycles.
        check("t2_head", bus.instr_pc, 32'h8);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", 32'(bus.instr_valid), 32'h1);
            check("t2_hold_instr", bus.instr, 32'h1000_0002);
        end
        check("t2_A_stall", bus.A, 32'h10);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_valid", 32'(bus.instr_valid), 32'h1);
            check("t2_pc", bus.instr_pc, 32'h8 + 32'(4 * i));
            tick();
        end

        // Redirect near the end of memory, then run into the fault.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3FC;
        tick();
        bus.redirect_valid = 1'b0;
        check("t3_flush", 32'(bus.instr_valid), 32'h0);
        tick(); check("t3_gap", 32'(bus.instr_valid), 32'h0);
        tick();
        check("t3_pc", bus.instr_pc, 32'h3FC);
        check("t3_instr", bus.instr, 32'h1000_00FF);
        tick();
        check("t3_fault_valid", 32'(bus.instr_valid), 32'h1);
        check("t3_fault_pc", bus.instr_pc, 32'h400);
        check("t3_fault_instr", bus.instr, NOP);
        check("t3_fault_flag", 32'(bus.instr_fault), 32'h1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t3_halt", 32'(bus.instr_valid), 32'h0);
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        tick(); tick();
        check("t3_restart_pc", bus.instr_pc, 32'h0);
        check("t3_restart_instr", bus.instr, 32'h1000_0000);

        // Misaligned redirect target.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h13;
        tick();
        bus.redirect_valid = 1'b0;
        tick(); tick();
        check("t4_valid", 32'(bus.instr_valid), 32'h1);
        check("t4_pc", bus.instr_pc, 32'h10);
        check("t4_instr", bus.instr, 32'h1000_0004);

        // fetch_en low with a word in flight: drain, hold A, resume sequentially.
        tick(); tick(); tick();
        bus.fetch_en = 1'b0;
        tick(); tick(); tick();
        check("t6_drained", 32'(bus.instr_valid), 32'h0);
        check("t6_A_hold", bus.A, exp_pc);
        tick();
        check("t6_A_hold2", bus.A, exp_pc);
        bus.fetch_en = 1'b1;
        wait_valid("t6_resume_valid", 6);
        check("t6_resume_pc", bus.instr_pc, exp_pc);

        // Reset in the middle of the stream.
        tick(); tick();
        apply_reset();
        bus.fetch_en    = 1'b1;
        bus.instr_ready = 1'b1;
        wait_valid("t5_restart_valid", 6);
        check("t5_restart_pc", bus.instr_pc, 32'h0);
        check("t5_restart_instr", bus.instr, 32'h1000_0000);

        // Random traffic against the stream model.
        for (int c = 0; c < 3000; c++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) bus.fetch_en = ~bus.fetch_en;
            case ($urandom_range(0, 3))
                0:       rpc = 32'($urandom_range(0, 1023));
                1:       rpc = 32'h3E0 + 32'($urandom_range(0, 31));
                2:       rpc = $urandom;
                default: rpc = 32'($urandom_range(0, 255));
            endcase
            bus.redirect_pc    = rpc;
            bus.redirect_valid = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 999) == 0) apply_reset();
            else                             tick();
        end
        check("random_progress", 32'(deliveries > 300), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
